dbus_bridge: RTL and testbench
==============================

DBUS_BRIDGE -- requirements
Module: dbus_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: bus cycles allowed from o_bus_req rising to i_bus_ack before abort; used only with DBUS_TIMEOUT_EN.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_clk_ce  input  1  upstream clock enable.
REQ-005 o_clk_ce  output  1  clock enable to cpu i_clk_ce; low stalls the whole pipeline.
REQ-006 i_addr  input  32  CPU data address.
REQ-007 i_data_wr  input  32  CPU store data, already lane-aligned.
REQ-008 i_wr  input  4  byte write strobes, not gated by clk_ce.
REQ-009 i_rd  input  1  read strobe, not gated by clk_ce.
REQ-010 o_data_rd  output  32  read data to cpu i_data_rd_d.
REQ-011 o_bus_req  output  1  bus request, level, registered.
REQ-012 o_bus_addr  output  32  registered address, word-aligned ([1:0]=0).
REQ-013 o_bus_wdata  output  32  registered store data.
REQ-014 o_bus_be  output  4  registered byte enables; 0000 on reads.
REQ-015 o_bus_wr  output  1  1=write, 0=read; valid while o_bus_req=1.
REQ-016 i_bus_ack  input  1  one-cycle completion strobe from slave.
REQ-017 i_bus_rdata  input  32  read data, valid when i_bus_ack=1.
REQ-018 o_err  output  1  one-cycle bus-timeout pulse.

Function
REQ-019 States SHALL be IDLE, BUSY, DONE.
REQ-020 In IDLE, request = i_rd or any i_wr bit; if set, o_clk_ce SHALL be 0 combinationally in the same cycle, and the request SHALL be latched, setting o_bus_req=1 and moving to BUSY on the next edge.
REQ-021 In IDLE with no request, o_clk_ce SHALL equal i_clk_ce.
REQ-022 In BUSY, o_clk_ce SHALL be 0, and o_bus_* SHALL hold stable until i_bus_ack.
REQ-023 On i_bus_ack in BUSY, o_bus_req SHALL clear on the next edge, read data SHALL be captured into the o_data_rd register (held unchanged for writes), and the state SHALL move to DONE.
REQ-024 In DONE, o_clk_ce SHALL equal i_clk_ce; the state SHALL stay in DONE while i_clk_ce=0 and return to IDLE on the first edge with i_clk_ce=1, so the completed access is never reissued.
REQ-025 o_data_rd SHALL hold its last captured value until the next read completes.
REQ-026 Minimum stall SHALL be 2 cycles: request seen at cycle N, o_bus_req=1 at N+1, ack at N+1, DONE at N+2.
REQ-027 i_bus_ack outside BUSY SHALL be ignored.
REQ-028 If i_rd and i_wr are both nonzero, the access SHALL be a write.

Reset
REQ-029 On i_rst, the following SHALL apply on the next edge regardless of state, with any in-flight bus request dropped without waiting for ack: state=IDLE, o_bus_req=0, o_bus_wr=0, o_bus_be=0, o_bus_addr=0, o_bus_wdata=0, o_data_rd=0, o_err=0, timeout counter=0.
REQ-030 While i_rst=1, o_clk_ce SHALL equal i_clk_ce.

Configuration
REQ-031 Macro DBUS_TIMEOUT_EN, defined: a counter SHALL clear on entry to BUSY and increment each BUSY cycle; on reaching TIMEOUT_CYCLES without ack, the following SHALL apply on the next edge: o_bus_req=0, o_data_rd=32'hFFFFFFFF, o_err pulses 1 for one cycle, state=DONE.
REQ-032 If ack and timeout occur in the same cycle, the ack SHALL take priority and o_err SHALL stay 0.
REQ-033 Macro DBUS_TIMEOUT_EN, undefined: BUSY SHALL wait indefinitely, no counter SHALL exist, and o_err SHALL be tied 0.

Verification
REQ-034 Read: i_rd=1, i_addr=32'h0000_1006, slave acks 3 cycles after req with rdata 32'hDEADBEEF -> o_bus_addr=32'h0000_1004, o_bus_be=0000, o_clk_ce low 5 cycles, then o_data_rd=32'hDEADBEEF with one o_clk_ce=1 cycle.
REQ-035 Write: i_wr=4'b0011, i_data_wr=32'h0000_ABCD, immediate ack -> o_bus_wr=1, o_bus_be=0011, o_bus_wdata=32'h0000_ABCD, 2-cycle stall, o_data_rd unchanged.
REQ-036 DONE with i_clk_ce=0 held 4 cycles -> stays DONE, no second o_bus_req; i_clk_ce=1 -> IDLE after one edge.
REQ-037 Reset in BUSY: i_rst one cycle -> o_bus_req=0 next edge, then a late i_bus_ack is ignored and the state stays IDLE.
REQ-038 With DBUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> o_err one-cycle pulse, o_data_rd=32'hFFFFFFFF, pipeline released; ack at the timeout cycle -> o_err=0, slave data returned.

Source files
------------

// File: rtl/dbus_bridge.sv
// Stalling bridge from the CPU data port to a req/ack data bus.
// Optional bus-timeout abort is built when DBUS_TIMEOUT_EN is defined.
module dbus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_ce,
    output logic        o_clk_ce,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data_wr,
    input  logic [3:0]  i_wr,
    input  logic        i_rd,
    output logic [31:0] o_data_rd,
    output logic        o_bus_req,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    output logic        o_bus_wr,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;
    logic   req;
    logic   timeout;

    logic [1:0] unused_addr_lo;
    assign unused_addr_lo = i_addr[1:0];

    assign req = i_rd | (|i_wr);

`ifdef DBUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] to_cnt;

    // Counts BUSY cycles; held at zero everywhere else.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            to_cnt <= '0;
        end else if (state != BUSY) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = (state == BUSY) &&
                     (to_cnt == CW'(TIMEOUT_CYCLES - 1));

    // An ack in the timeout cycle wins, so no error is flagged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else begin
            o_err <= timeout && !i_bus_ack;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
    assign o_err   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (req) state_nx = BUSY;
            BUSY: if (i_bus_ack || timeout) state_nx = DONE;
            DONE: if (i_clk_ce) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_clk_ce = i_clk_ce;
        if (!i_rst) begin
            unique case (state)
                IDLE: if (req) o_clk_ce = 1'b0;
                BUSY: o_clk_ce = 1'b0;
                default: o_clk_ce = i_clk_ce;
            endcase
        end
    end

    // A store with a read strobe still wins: be/wr come from i_wr.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_bus_req   <= 1'b0;
            o_bus_wr    <= 1'b0;
            o_bus_be    <= 4'b0000;
            o_bus_addr  <= 32'h0;
            o_bus_wdata <= 32'h0;
            o_data_rd   <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        o_bus_req   <= 1'b1;
                        o_bus_wr    <= |i_wr;
                        o_bus_be    <= i_wr;
                        o_bus_addr  <= {i_addr[31:2], 2'b00};
                        o_bus_wdata <= i_data_wr;
                    end
                end
                BUSY: begin
                    if (i_bus_ack) begin
                        o_bus_req <= 1'b0;
                        if (!o_bus_wr) o_data_rd <= i_bus_rdata;
                    end else if (timeout) begin
                        o_bus_req <= 1'b0;
                        o_data_rd <= 32'hFFFF_FFFF;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed bench for dbus_bridge: reads, writes, DONE hold,
// reset mid-access and (with DBUS_TIMEOUT_EN) the timeout path.
`timescale 1ns/1ps
module tb_dbus_bridge;

    logic        i_clk;
    logic        i_rst;
    logic        i_clk_ce;
    logic        o_clk_ce;
    logic [31:0] i_addr;
    logic [31:0] i_data_wr;
    logic [3:0]  i_wr;
    logic        i_rd;
    logic [31:0] o_data_rd;
    logic        o_bus_req;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        o_bus_wr;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        o_err;

    int total;
    int bad;

    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_wr;
    logic        unstable;
    int          stall;

    dbus_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clk_ce    (i_clk_ce),
        .o_clk_ce    (o_clk_ce),
        .i_addr      (i_addr),
        .i_data_wr   (i_data_wr),
        .i_wr        (i_wr),
        .i_rd        (i_rd),
        .o_data_rd   (o_data_rd),
        .o_bus_req   (o_bus_req),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wdata (o_bus_wdata),
        .o_bus_be    (o_bus_be),
        .o_bus_wr    (o_bus_wr),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata),
        .o_err       (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Strobes must already be driven; returns in the first cycle
    // with o_clk_ce high. Slave acks ack_dly cycles after req rises.
    task automatic run_access(input int ack_dly,
                              input logic [31:0] rdata);
        int reqcyc;
        reqcyc   = 0;
        stall    = 0;
        unstable = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (o_clk_ce) break;
            stall++;
            if (o_bus_req) begin
                if (reqcyc == 0) begin
                    seen_addr  = o_bus_addr;
                    seen_wdata = o_bus_wdata;
                    seen_be    = o_bus_be;
                    seen_wr    = o_bus_wr;
                end else if (o_bus_addr !== seen_addr ||
                             o_bus_wdata !== seen_wdata ||
                             o_bus_be !== seen_be ||
                             o_bus_wr !== seen_wr) begin
                    unstable = 1'b1;
                end
                i_bus_ack   = (reqcyc == ack_dly);
                i_bus_rdata = rdata;
                reqcyc++;
            end
            tick();
            i_bus_ack = 1'b0;
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        i_rst       = 1'b1;
        i_clk_ce    = 1'b1;
        i_addr      = 32'h0;
        i_data_wr   = 32'h0;
        i_wr        = 4'b0000;
        i_rd        = 1'b0;
        i_bus_ack   = 1'b0;
        i_bus_rdata = 32'h0;
        tick();
        tick();
        chk("rst_req", 32'(o_bus_req), 32'h0);
        chk("rst_addr", o_bus_addr, 32'h0);
        chk("rst_be", 32'(o_bus_be), 32'h0);
        chk("rst_data", o_data_rd, 32'h0);
        chk("rst_err", 32'(o_err), 32'h0);
        chk("rst_ce1", 32'(o_clk_ce), 32'h1);
        i_clk_ce = 1'b0;
        #1;
        chk("rst_ce0", 32'(o_clk_ce), 32'h0);
        tick();
        i_rst    = 1'b0;
        i_clk_ce = 1'b1;
        #1;
        chk("idle_ce", 32'(o_clk_ce), 32'h1);

        // read with ack three cycles after req
        tick();
        i_rd   = 1'b1;
        i_addr = 32'h0000_1006;
        #1;
        chk("rd_ce_comb", 32'(o_clk_ce), 32'h0);
        run_access(3, 32'hDEAD_BEEF);
        chk("rd_stall", 32'(stall), 32'd5);
        chk("rd_addr", seen_addr, 32'h0000_1004);
        chk("rd_be", 32'(seen_be), 32'h0);
        chk("rd_wr", 32'(seen_wr), 32'h0);
        chk("rd_stable", 32'(unstable), 32'h0);
        chk("rd_data", o_data_rd, 32'hDEAD_BEEF);
        chk("rd_req_off", 32'(o_bus_req), 32'h0);
        chk("rd_err", 32'(o_err), 32'h0);
        tick();
        i_rd = 1'b0;
        #1;
        chk("rd_idle_ce", 32'(o_clk_ce), 32'h1);
        chk("rd_no_reissue", 32'(o_bus_req), 32'h0);

        // write with immediate ack
        tick();
        i_wr      = 4'b0011;
        i_data_wr = 32'h0000_ABCD;
        i_addr    = 32'h0000_2000;
        run_access(0, 32'h5555_5555);
        chk("wr_stall", 32'(stall), 32'd2);
        chk("wr_wr", 32'(seen_wr), 32'h1);
        chk("wr_be", 32'(seen_be), 32'h3);
        chk("wr_wdata", seen_wdata, 32'h0000_ABCD);
        chk("wr_addr", seen_addr, 32'h0000_2000);
        chk("wr_data_hold", o_data_rd, 32'hDEAD_BEEF);
        tick();
        i_wr = 4'b0000;

        // read and write strobes together -> write
        tick();
        i_rd      = 1'b1;
        i_wr      = 4'b1000;
        i_data_wr = 32'h7700_0000;
        i_addr    = 32'h0000_2443;
        run_access(1, 32'h1111_2222);
        chk("rw_stall", 32'(stall), 32'd3);
        chk("rw_wr", 32'(seen_wr), 32'h1);
        chk("rw_be", 32'(seen_be), 32'h8);
        chk("rw_addr", seen_addr, 32'h0000_2440);
        chk("rw_data_hold", o_data_rd, 32'hDEAD_BEEF);
        tick();
        i_rd = 1'b0;
        i_wr = 4'b0000;

        // DONE held with upstream clock enable low
        tick();
        i_clk_ce = 1'b0;
        i_rd     = 1'b1;
        i_addr   = 32'h0000_3000;
        #1;
        chk("dh_ce_comb", 32'(o_clk_ce), 32'h0);
        tick();
        chk("dh_req", 32'(o_bus_req), 32'h1);
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'h1234_5678;
        tick();
        i_bus_ack = 1'b0;
        chk("dh_data", o_data_rd, 32'h1234_5678);
        for (int k = 0; k < 4; k++) begin
            chk("dh_no_req", 32'(o_bus_req), 32'h0);
            tick();
        end
        chk("dh_ce_low", 32'(o_clk_ce), 32'h0);
        chk("dh_still_no_req", 32'(o_bus_req), 32'h0);
        i_clk_ce = 1'b1;
        #1;
        chk("dh_ce_rel", 32'(o_clk_ce), 32'h1);
        tick();
        i_rd = 1'b0;
        #1;
        chk("dh_idle_ce", 32'(o_clk_ce), 32'h1);
        chk("dh_idle_req", 32'(o_bus_req), 32'h0);

        // reset while BUSY, then a stray ack
        tick();
        i_rd   = 1'b1;
        i_addr = 32'h0000_4000;
        tick();
        chk("rb_req", 32'(o_bus_req), 32'h1);
        i_rst = 1'b1;
        tick();
        chk("rb_req_drop", 32'(o_bus_req), 32'h0);
        chk("rb_data_clr", o_data_rd, 32'h0);
        i_rst       = 1'b0;
        i_rd        = 1'b0;
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'hAAAA_5555;
        #1;
        chk("rb_ack_ce", 32'(o_clk_ce), 32'h1);
        tick();
        i_bus_ack = 1'b0;
        chk("rb_ack_req", 32'(o_bus_req), 32'h0);
        chk("rb_ack_data", o_data_rd, 32'h0);
        #1;
        chk("rb_idle_ce", 32'(o_clk_ce), 32'h1);

`ifdef DBUS_TIMEOUT_EN
        // no ack: abort after four BUSY cycles
        tick();
        i_rd   = 1'b1;
        i_addr = 32'h0000_5000;
        run_access(100, 32'h0);
        chk("to_stall", 32'(stall), 32'd5);
        chk("to_err", 32'(o_err), 32'h1);
        chk("to_data", o_data_rd, 32'hFFFF_FFFF);
        chk("to_req", 32'(o_bus_req), 32'h0);
        tick();
        i_rd = 1'b0;
        chk("to_err_pulse", 32'(o_err), 32'h0);

        // ack in the timeout cycle wins
        tick();
        i_rd   = 1'b1;
        i_addr = 32'h0000_6000;
        run_access(3, 32'hCAFE_F00D);
        chk("ta_stall", 32'(stall), 32'd5);
        chk("ta_err", 32'(o_err), 32'h0);
        chk("ta_data", o_data_rd, 32'hCAFE_F00D);
        tick();
        i_rd = 1'b0;
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
